sti_rx: RTL
===========

# sti_rx

Serial-to-parallel receiver for the STI serial link: it samples the bit stream (`si_data` qualified by `si_valid`) and rebuilds the 16-bit parallel word. Framing is controlled by the same length, bit-order, fill and low-byte controls the transmitter uses. Completed words go into a 2-entry output FIFO with a valid/ready handshake toward the downstream consumer. It sits at the far end of the STI link, as the counterpart of the STI transmitter.

## Interface
- No parameters; FIFO depth fixed at 2, word width fixed at 16.
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `si_data`  in  1  serial bit, sampled when `si_valid`=1
- `si_valid`  in  1  bit qualifier; frames are contiguous runs of valid bits
- `cfg_length`  in  2  frame length: 00=8, 01=16, 10=24, 11=32 bits
- `cfg_msb`  in  1  1: first bit received is word MSB; 0: first bit is LSB
- `cfg_fill`  in  1  payload position for 24/32-bit frames (see Operation)
- `cfg_low`  in  1  8-bit frames: 1 puts byte in `po_data[15:8]`, 0 in `[7:0]`
- `cfg_end`  in  1  stream-end indication
- `po_data`  out  16  FIFO head word
- `po_valid`  out  1  FIFO non-empty
- `po_ready`  in  1  consumer accepts head word when `po_valid`&`po_ready`
- `po_err`  out  1  one-cycle short-frame pulse
- `rx_ovf`  out  1  sticky: a completed word was dropped because the FIFO was full
- `rx_done`  out  1  sticky: stream ended and all words were drained

## Operation
- FSM states: IDLE, SHIFT, FINISH. Reset enters IDLE.
- IDLE → SHIFT on the first valid bit. On that edge, `cfg_length`/`cfg_msb`/`cfg_fill`/`cfg_low` are latched; they are ignored for the rest of the frame. Bit counter = 1.
- SHIFT: each valid bit is stored into word W at N−k (msb) or k−1 (lsb), where k = bit number from 1 and N = frame length.
- The frame completes on the edge that samples bit N. That edge pushes the extracted word and returns the FSM to IDLE. A valid bit on the following cycle starts a new frame, so back-to-back frames are allowed.
- Extraction from W:
  - N=8: byte W[7:0] in the upper or lower half per `cfg_low`; the other half is 0.
  - N=16: W[15:0].
  - N=24: W[23:8] if fill=1, else W[15:0].
  - N=32: W[31:16] if fill=1, else W[15:0].
- Short frame: `si_valid`=0 in SHIFT with count < N. The partial word is discarded and the FSM returns to IDLE; `po_err` handling is described under Configuration.
- FIFO:
  - Push and pop on the same edge are always legal, including when the FIFO is full.
  - Push while full with no pop: the new word is dropped, the FIFO is unchanged, and `rx_ovf` is set to 1.
  - Pop while empty is ignored.
- FINISH entry: the FSM is in IDLE, `cfg_end`=1, and the FIFO is empty (after any pop on that edge). On entry `rx_done` goes to 1.
- FINISH: serial input is ignored, the FIFO still drains, and the state is held until reset.
- `cfg_end` seen during SHIFT has no effect; it is re-evaluated once the FSM is back in IDLE.

## Timing
- Reset values: `po_data`=0, `po_valid`=0, `po_err`=0, `rx_ovf`=0, `rx_done`=0. FIFO is emptied, bit counter=0, W=0.
- Reset deasserted mid-frame: the partial frame is lost and no `po_err` is raised.
- Latency: the word is visible on `po_data` with `po_valid`=1 in the cycle after the edge that samples bit N, if the FIFO was empty.
- `po_data`/`po_valid` are registered. `po_data` is held stable while `po_valid`=1 and `po_ready`=0.
- `po_err` is high for exactly the one cycle after the edge that detects the short frame.
- `rx_done` rises on the edge after the last pop that empties the FIFO with `cfg_end`=1 held.

## Configuration
- `STI_RX_ERR_EN` defined: short-frame detection drives `po_err` as specified.
- `STI_RX_ERR_EN` undefined: `po_err` is tied to 0; short frames are still discarded silently and the FSM returns to IDLE.

## Test plan
- 16-bit, msb=1, bits of 0xA5C3 sent MSB first, `po_ready`=1 → `po_data`=0xA5C3 with `po_valid` high for 1 cycle, starting one cycle after the last bit.
- 8-bit, msb=0, low=1, bits of 0x3C sent LSB first → `po_data`=0x3C00. Same with low=0 → 0x003C.
- 24-bit and 32-bit frames with fill=0/1; 32-bit msb=1 stream 0x1234ABCD → fill=1: 0x1234, fill=0: 0xABCD.
- `po_ready`=0, three 16-bit frames back-to-back → two words held in order, third dropped, `rx_ovf`=1. Raising `po_ready` pops the first two words.
- `si_valid` dropped after 5 bits of a 16-bit frame → `po_err` 1-cycle pulse (with `STI_RX_ERR_EN`), no push. A following full frame is received correctly.
- `cfg_end`=1 with 1 word buffered, `po_ready`=1 → word popped, `rx_done`=1 next cycle; subsequent `si_valid` bits are ignored.

Source files
------------

// File: rtl/sti_rx.sv
`default_nettype none
// ============================================================================
// Module   : sti_rx
// Brief    : STI serial receiver. Rebuilds 16-bit words from a framed bit
//            stream and buffers them in a 2-entry valid/ready output FIFO.
//            Optional macro STI_RX_ERR_EN enables the po_err short-frame pulse.
// Revision : 1.0  initial release
// ============================================================================
module sti_rx (
    input  logic        clk,
    input  logic        reset,
    input  logic        si_data,
    input  logic        si_valid,
    input  logic [1:0]  cfg_length,
    input  logic        cfg_msb,
    input  logic        cfg_fill,
    input  logic        cfg_low,
    input  logic        cfg_end,
    output logic [15:0] po_data,
    output logic        po_valid,
    input  logic        po_ready,
    output logic        po_err,
    output logic        rx_ovf,
    output logic        rx_done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_word;
    logic [1:0]  r_len;
    logic        r_msb;
    logic        r_fill;
    logic        r_low;
    logic [15:0] r_head;
    logic [15:0] r_tail;
    logic [1:0]  r_fcnt;
    logic        r_ovf;
    logic        r_done;

    logic        w_idle;
    logic [1:0]  w_len_sel;
    logic        w_msb_sel;
    logic [5:0]  w_k;
    logic [5:0]  w_n;
    logic [5:0]  w_pos;
    logic [31:0] w_word_next;
    logic        w_complete;
    logic [15:0] w_push_data;
    logic        w_pop;
    logic        w_drained;

    // The first bit of a frame is sampled in IDLE, so the live cfg inputs
    // decide its position; later bits use the values latched on that edge.
    assign w_idle    = (r_state == S_IDLE);
    assign w_len_sel = w_idle ? cfg_length : r_len;
    assign w_msb_sel = w_idle ? cfg_msb : r_msb;
    assign w_k       = w_idle ? 6'd1 : (r_cnt + 6'd1);
    assign w_n       = {1'b0, w_len_sel, 3'b000} + 6'd8;
    assign w_pos     = w_msb_sel ? (w_n - w_k) : (w_k - 6'd1);

    always_comb begin
        w_word_next             = w_idle ? 32'd0 : r_word;
        w_word_next[w_pos[4:0]] = si_data;
    end

    assign w_complete = (r_state == S_SHIFT) && si_valid && (w_k == w_n);

    always_comb begin
        w_push_data = w_word_next[15:0];
        case (r_len)
            2'd0: w_push_data = r_low ? {w_word_next[7:0], 8'h00}
                                      : {8'h00, w_word_next[7:0]};
            2'd1: w_push_data = w_word_next[15:0];
            2'd2: w_push_data = r_fill ? w_word_next[23:8]  : w_word_next[15:0];
            2'd3: w_push_data = r_fill ? w_word_next[31:16] : w_word_next[15:0];
            default: w_push_data = w_word_next[15:0];
        endcase
    end

    assign po_valid  = (r_fcnt != 2'd0);
    assign po_data   = r_head;
    assign rx_ovf    = r_ovf;
    assign rx_done   = r_done;
    assign w_pop     = po_valid && po_ready;
    assign w_drained = (r_fcnt == 2'd0) || ((r_fcnt == 2'd1) && w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_word  <= 32'd0;
            r_len   <= 2'd0;
            r_msb   <= 1'b0;
            r_fill  <= 1'b0;
            r_low   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_end && w_drained) begin
                        r_state <= S_FINISH;
                        r_done  <= 1'b1;
                    end else if (si_valid) begin
                        r_state <= S_SHIFT;
                        r_len   <= cfg_length;
                        r_msb   <= cfg_msb;
                        r_fill  <= cfg_fill;
                        r_low   <= cfg_low;
                        r_cnt   <= 6'd1;
                        r_word  <= w_word_next;
                    end
                end
                S_SHIFT: begin
                    if (si_valid) begin
                        r_word <= w_word_next;
                        if (w_complete) begin
                            r_state <= S_IDLE;
                            r_cnt   <= 6'd0;
                        end else begin
                            r_cnt <= w_k;
                        end
                    end else begin
                        // Short frame: partial word is simply abandoned.
                        r_state <= S_IDLE;
                        r_cnt   <= 6'd0;
                    end
                end
                S_FINISH: r_state <= S_FINISH;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Two-entry FIFO; r_head is the registered output word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head <= 16'd0;
            r_tail <= 16'd0;
            r_fcnt <= 2'd0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_fcnt)
                2'd0: begin
                    if (w_complete) begin
                        r_head <= w_push_data;
                        r_fcnt <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({w_complete, w_pop})
                        2'b11:   r_head <= w_push_data;
                        2'b01:   r_fcnt <= 2'd0;
                        2'b10: begin
                            r_tail <= w_push_data;
                            r_fcnt <= 2'd2;
                        end
                        default: r_fcnt <= 2'd1;
                    endcase
                end
                2'd2: begin
                    case ({w_complete, w_pop})
                        2'b11: begin
                            r_head <= r_tail;
                            r_tail <= w_push_data;
                        end
                        2'b01: begin
                            r_head <= r_tail;
                            r_fcnt <= 2'd1;
                        end
                        2'b10:   r_ovf  <= 1'b1;
                        default: r_fcnt <= 2'd2;
                    endcase
                end
                default: r_fcnt <= 2'd0;
            endcase
        end
    end

`ifdef STI_RX_ERR_EN
    logic w_short;
    logic r_err;

    assign w_short = (r_state == S_SHIFT) && !si_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_short;
        end
    end

    assign po_err = r_err;
`else
    assign po_err = 1'b0;
`endif

endmodule
`default_nettype wire
